truth_table_sweeper: RTL

Sequencer that exhaustively drives every input combination into an external N_IN-input combinational function unit (the six-variable logic block) and captures its single-bit response. It builds the full truth table and a ones-count in hardware, replacing hand-written stimulus lists. It sits between a control/status host (start/done) and the function unit's input vector and output bit.

---
 rtl/truth_table_sweeper_pkg.sv | 25 ++
 rtl/truth_table_sweeper_sweep_counter.sv | 61 ++++++
 rtl/truth_table_sweeper.sv | 122 ++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package truth_table_sweeper_pkg;

   // Sweep sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sweep_state_t;

   // Default function-unit width and the matching number of input vectors.
   localparam int unsigned DEF_N_IN = 6;
   localparam int unsigned NUM_VEC  = 2 ** DEF_N_IN;

   // Settle down-counter width; SETTLE is limited to 0..15.
   localparam int unsigned SETTLE_W = 4;

   // Number of vectors swept for an n-input function unit.
   function automatic int unsigned vec_count(input int unsigned n);
      return 32'd1 << n;
   endfunction

endpackage

// File: rtl/truth_table_sweeper_sweep_counter.sv
// Vector index counter plus per-vector settle down-counter for the sweeper.
// Latency: sample_now is combinational from the registered counters; vec advances one edge after a sample.
// Backpressure: run_en low freezes both counters (used to implement hold).
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   load         restart: vec <- 0, settle counter <- SETTLE
//   run_en       advance enable (RUN and not held)
//   park         return vec to 0 on leaving DONE
//   vec          current input vector
//   sample_now   y_in is to be captured on this edge
//   last_vec     vec is the final vector (all ones)
module truth_table_sweeper_sweep_counter
   import truth_table_sweeper_pkg::*;
#(
   parameter int N_IN   = 6,
   parameter int SETTLE = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            run_en,
   input  logic            park,
   output logic [N_IN-1:0] vec,
   output logic            sample_now,
   output logic            last_vec
);

   localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE);

   logic [N_IN-1:0]     vec_q;
   logic [SETTLE_W-1:0] settle_q;

   assign vec        = vec_q;
   assign last_vec   = (vec_q == {N_IN{1'b1}});
   // A vector is sampled on the first un-held edge where its settle time has run out.
   assign sample_now = run_en && (settle_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_q    <= '0;
         settle_q <= '0;
      end else if (load) begin
         vec_q    <= '0;
         settle_q <= SETTLE_LD;
      end else if (park) begin
         vec_q    <= '0;
         settle_q <= '0;
      end else if (run_en) begin
         if (settle_q != '0) begin
            settle_q <= settle_q - 1'b1;
         end else if (!last_vec) begin
            vec_q    <= vec_q + 1'b1;
            settle_q <= SETTLE_LD;
         end
         // On the last vector vec_q is held rather than wrapping; the FSM
         // leaves RUN on this same edge.
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive sweeper: drives every N_IN-bit vector into a function unit and records its truth table.
// Latency: start accepted at edge k -> last sample at edge k + 2**N_IN*(SETTLE+1), done high the cycle after.
// Backpressure: hold freezes the sweep in RUN (no advance, no sample); start ignored outside IDLE.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        begin a sweep (accepted only in IDLE)
//   hold         freeze the sweep while high (RUN only)
//   vec_out      registered input vector to the function unit
//   y_in         function unit output, sampled synchronously
//   busy         high while sweeping
//   done         one-cycle pulse after the last sample
//   table_out    captured truth table, bit i = y for vector i
//   ones_count   number of vectors with y = 1
//   any_one      ones_count != 0
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter int N_IN   = 6,
   parameter int SETTLE = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   hold,
   output logic [N_IN-1:0]        vec_out,
   input  logic                   y_in,
   output logic                   busy,
   output logic                   done,
   output logic [(1<<N_IN)-1:0]   table_out,
   output logic [N_IN:0]          ones_count,
   output logic                   any_one
);

   localparam int unsigned N_VEC = vec_count(N_IN);

   sweep_state_t state_q, state_d;

   logic             accept;
   logic             run_en;
   logic             park;
   logic             sample_now;
   logic             last_vec;
   logic [N_IN-1:0]  vec;

   logic [N_VEC-1:0] table_q;
   logic [N_IN:0]    ones_q;

   assign accept = (state_q == ST_IDLE) && start;
   assign run_en = (state_q == ST_RUN) && !hold;
   assign park   = (state_q == ST_DONE);

   truth_table_sweeper_sweep_counter #(
      .N_IN   (N_IN),
      .SETTLE (SETTLE)
   ) u_sweep_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (accept),
      .run_en     (run_en),
      .park       (park),
      .vec        (vec),
      .sample_now (sample_now),
      .last_vec   (last_vec)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and status outputs.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (sample_now && last_vec) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Result capture: cleared on an accepted start, otherwise held until then.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         table_q <= '0;
         ones_q  <= '0;
      end else if (accept) begin
         table_q <= '0;
         ones_q  <= '0;
      end else if (sample_now) begin
         table_q[vec] <= y_in;
         ones_q       <= ones_q + {{N_IN{1'b0}}, y_in};
      end
   end

   assign vec_out    = vec;
   assign table_out  = table_q;
   assign ones_count = ones_q;
   assign any_one    = (ones_q != '0);

endmodule
